countdown_timer_ctrl: RTL and testbench
=======================================

// Module: countdown_timer_ctrl
// PURPOSE
//  MM:SS countdown controller that sits directly upstream of the FND finish-blink stage.
//  - Presets and runs a countdown, and drives BCD digits to the normal FND scanner.
//  - At 00:00 it raises a level request that starts the blink stage, then waits for that stage's finish tick.
//  - It then reloads the preset time and returns to IDLE.
// PARAMETERS
//  SEC_DIV      100_000_000  clk cycles per 1 s countdown step (1 s at 100 MHz)
//  TIMEOUT_CYC  500_000_000  max cycles to wait for i_finish (used only with the macro)
// PORTS
//  clk           in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-low reset
//  i_run         in   1  1-cycle pulse: start / pause / resume
//  i_clear       in   1  1-cycle pulse: abort and zero the time
//  i_min_up      in   1  1-cycle pulse: minutes +1 (IDLE only)
//  i_sec_up      in   1  1-cycle pulse: seconds +1 (IDLE only)
//  i_finish      in   1  1-cycle tick from the blink stage: blink sequence complete
//  o_min_tens    out  4  BCD minutes tens, 0..5
//  o_min_ones    out  4  BCD minutes ones, 0..9
//  o_sec_tens    out  4  BCD seconds tens, 0..5
//  o_sec_ones    out  4  BCD seconds ones, 0..9
//  o_running     out  1  high in RUN only
//  o_finish_req  out  1  level, high in FINISH only; drives the blink stage's state input
//  o_done        out  1  1-cycle pulse when FINISH completes normally
//  o_timeout     out  1  1-cycle pulse on finish wait timeout (0 when the macro is off)
// BEHAVIOUR
//  - Reset: state=IDLE, all digits 0, preset 00:00, prescaler 0, all outputs 0.
//  - States: IDLE, RUN, PAUSE, FINISH. All outputs are registered.
//  - Priority every cycle: i_clear > i_run > tick/i_finish > i_min_up/i_sec_up.
//  - IDLE:
//    - i_min_up: minutes 00..59, wrapping 59->00.
//    - i_sec_up: seconds 00..59, wrapping 59->00, with no carry into minutes.
//    - Both pulses in one cycle: both applied.
//    - i_run with time != 00:00: copy time into preset, prescaler=0, go to RUN next cycle.
//    - i_run with time == 00:00: ignored.
//    - i_run together with a set pulse: the set pulse is dropped.
//  - RUN:
//    - Prescaler counts 0..SEC_DIV-1. At SEC_DIV-1 it wraps to 0 and the time decrements by 1 s.
//    - BCD borrow: sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones; min_ones 0->9 borrows min_tens.
//    - Decrement 00:01->00:00: the same edge enters FINISH, so o_finish_req rises with digits 00:00.
//    - i_run: go to PAUSE; prescaler held, not cleared.
//  - PAUSE:
//    - Digits and prescaler frozen.
//    - i_run: back to RUN, prescaler continues from its held value.
//    - Set pulses ignored.
//  - FINISH:
//    - o_finish_req=1; digits hold 00:00.
//    - i_finish: next cycle o_finish_req=0, o_done=1 for 1 cycle, digits=preset, state=IDLE.
//    - i_run and set pulses ignored.
//  - i_clear in any state: next cycle IDLE, digits 00:00, prescaler 0, o_finish_req=0, no o_done.
//    - i_clear wins over a simultaneous i_finish or tick.
//  - The preset register is not changed by i_clear.
//  - i_finish outside FINISH: ignored.
//  - Async reset mid-operation: immediate return to reset values, including o_finish_req=0.
// CONFIGURATION
//  - CDT_FINISH_TIMEOUT_EN defined:
//    - A cycle counter runs in FINISH.
//    - If i_finish is absent for TIMEOUT_CYC cycles: o_timeout=1 for 1 cycle, o_finish_req=0, digits=preset, state=IDLE.
//    - No o_done on timeout.
//  - Not defined: no counter; FINISH waits for i_finish indefinitely; o_timeout tied 0.
// TESTING (SEC_DIV=10, TIMEOUT_CYC=200)
//  1. Set: 3x i_sec_up, i_run. -> o_running=1; 00:02 after 10 cycles; 00:00 and o_finish_req=1 after 30 cycles.
//     Then i_finish pulse -> o_done 1 cycle, display 00:03, IDLE.
//  2. Borrow: set 01:00, run. -> 00:59 after 10 cycles.
//     Set 10:00, run. -> 09:59 after 10 cycles.
//  3. Wrap and ignore: 60x i_sec_up -> 00:00; 61x i_min_up -> 01:00.
//     i_run at 00:00 -> stays IDLE, o_running=0.
//  4. Pause/resume: run 00:05; i_run at prescaler=4; hold 100 cycles -> digits unchanged.
//     i_run -> decrement exactly 6 cycles after resume.
//  5. Clear/reset: i_clear together with i_finish in FINISH -> IDLE 00:00, o_done never 1.
//     Drive reset low mid-RUN -> all outputs 0 immediately.
//  6. Macro on: reach FINISH, no i_finish -> o_timeout pulse after 200 cycles, o_finish_req=0, preset reloaded.
//     Macro off: o_finish_req stays 1 for 1000 cycles.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown controller feeding the FND finish-blink stage.
// Optional finish-wait timeout is enabled by defining CDT_FINISH_TIMEOUT_EN.
module countdown_timer_ctrl #(
  parameter int unsigned SEC_DIV     = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_clear,
  input  logic       i_min_up,
  input  logic       i_sec_up,
  input  logic       i_finish,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_running,
  output logic       o_finish_req,
  output logic       o_done,
  output logic       o_timeout
);

  localparam int unsigned PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SEC_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [15:0]   cur_time;
  logic [15:0]   preset;
  logic          tick;
  logic          time_zero;
  logic          time_one;
  logic          timeout_hit;

  // BCD pair 00..59 increment, wrapping 59 -> 00
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [3:0] tens, ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd5) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // One-second decrement of MM:SS with BCD borrows; never applied at 00:00
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign cur_time  = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};
  assign time_zero = (cur_time == 16'h0000);
  assign time_one  = (cur_time == 16'h0001);
  assign tick      = (state_q == RUN) && (presc == PRESC_MAX);

`ifdef CDT_FINISH_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt;

  // Counts cycles spent waiting in FINISH; cleared on any exit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if ((state_q == FINISH) && (state_d == FINISH)) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = (state_q == FINISH) && (to_cnt == TO_MAX);
`else
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_run && !time_zero) state_d = RUN;
        RUN: begin
          if (i_run)                 state_d = PAUSE;
          else if (tick && time_one) state_d = FINISH;
        end
        PAUSE:   if (i_run) state_d = RUN;
        FINISH:  if (i_finish || timeout_hit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_running    = (state_q == RUN);
    o_finish_req = (state_q == FINISH);
  end

  // Digits, prescaler, preset and completion pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} <= 16'h0000;
      preset    <= 16'h0000;
      presc     <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      if (i_clear) begin
        {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} <= 16'h0000;
        presc <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_run) begin
              if (!time_zero) begin
                preset <= cur_time;
                presc  <= '0;
              end
            end else begin
              if (i_min_up) {o_min_tens, o_min_ones} <= inc60({o_min_tens, o_min_ones});
              if (i_sec_up) {o_sec_tens, o_sec_ones} <= inc60({o_sec_tens, o_sec_ones});
            end
          end
          RUN: begin
            if (!i_run) begin
              if (tick) begin
                presc <= '0;
                {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} <= dec_time(cur_time);
              end else begin
                presc <= presc + PW'(1);
              end
            end
          end
          FINISH: begin
            if (i_finish) begin
              {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} <= preset;
              o_done <= 1'b1;
            end else if (timeout_hit) begin
              {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} <= preset;
              o_timeout <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl (SEC_DIV=10, TIMEOUT_CYC=200).
module tb_countdown_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       i_run, i_clear, i_min_up, i_sec_up, i_finish;
  logic [3:0] o_min_tens, o_min_ones, o_sec_tens, o_sec_ones;
  logic       o_running, o_finish_req, o_done, o_timeout;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;

  countdown_timer_ctrl #(.SEC_DIV(10), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_clear(i_clear),
    .i_min_up(i_min_up), .i_sec_up(i_sec_up), .i_finish(i_finish),
    .o_min_tens(o_min_tens), .o_min_ones(o_min_ones),
    .o_sec_tens(o_sec_tens), .o_sec_ones(o_sec_ones),
    .o_running(o_running), .o_finish_req(o_finish_req),
    .o_done(o_done), .o_timeout(o_timeout)
  );

  assign disp = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run, clr, mu, su, fin;
    logic [15:0] disp;
    logic        running, freq, done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_run();
    i_run = 1'b1; cyc(); i_run = 1'b0;
  endtask

  task automatic pulse_sec(input int n);
    for (int k = 0; k < n; k++) begin
      i_sec_up = 1'b1; cyc(); i_sec_up = 1'b0;
    end
  endtask

  task automatic pulse_min(input int n);
    for (int k = 0; k < n; k++) begin
      i_min_up = 1'b1; cyc(); i_min_up = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    int bad;
    // run clr mu su fin | disp running freq done
    vecs[0] = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 1, 0, 16'h0001, 0, 0, 0};
    vecs[2] = '{0, 0, 1, 0, 0, 16'h0101, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 1, 0, 16'h0202, 0, 0, 0};
    vecs[4] = '{1, 0, 0, 1, 0, 16'h0202, 1, 0, 0};
    vecs[5] = '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 0};
    vecs[6] = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 1, 16'h0000, 0, 0, 0};
    vecs[8] = '{0, 0, 0, 1, 0, 16'h0001, 0, 0, 0};
    vecs[9] = '{1, 1, 0, 0, 0, 16'h0000, 0, 0, 0};

    {i_run, i_clear, i_min_up, i_sec_up, i_finish} = '0;
    do_reset();

    for (int v = 0; v < 10; v++) begin
      {i_run, i_clear, i_min_up, i_sec_up, i_finish} =
        {vecs[v].run, vecs[v].clr, vecs[v].mu, vecs[v].su, vecs[v].fin};
      cyc();
      {i_run, i_clear, i_min_up, i_sec_up, i_finish} = '0;
      check($sformatf("vec%0d_disp", v), disp, vecs[v].disp);
      check($sformatf("vec%0d_running", v), {15'd0, o_running}, {15'd0, vecs[v].running});
      check($sformatf("vec%0d_freq", v), {15'd0, o_finish_req}, {15'd0, vecs[v].freq});
      check($sformatf("vec%0d_done", v), {15'd0, o_done}, {15'd0, vecs[v].done});
    end

    // Basic countdown 00:03 through FINISH and handshake
    do_reset();
    pulse_sec(3);
    pulse_run();
    check("s1_running", {15'd0, o_running}, 16'd1);
    cyc(9);
    check("s1_before_tick", disp, 16'h0003);
    cyc(1);
    check("s1_first_tick", disp, 16'h0002);
    cyc(19);
    check("s1_before_finish", disp, 16'h0001);
    check("s1_freq_low", {15'd0, o_finish_req}, 16'd0);
    cyc(1);
    check("s1_zero", disp, 16'h0000);
    check("s1_freq_high", {15'd0, o_finish_req}, 16'd1);
    check("s1_not_running", {15'd0, o_running}, 16'd0);
    i_run = 1'b1; i_sec_up = 1'b1; cyc(); i_run = 1'b0; i_sec_up = 1'b0;
    check("s1_finish_ignores_run", {15'd0, o_finish_req}, 16'd1);
    check("s1_finish_ignores_set", disp, 16'h0000);
    i_finish = 1'b1; cyc(); i_finish = 1'b0;
    check("s1_done", {15'd0, o_done}, 16'd1);
    check("s1_freq_drop", {15'd0, o_finish_req}, 16'd0);
    check("s1_reload", disp, 16'h0003);
    cyc();
    check("s1_done_pulse", {15'd0, o_done}, 16'd0);
    check("s1_idle", {15'd0, o_running}, 16'd0);

    // Borrow chains
    do_reset();
    pulse_min(1);
    pulse_run();
    cyc(9);
    check("s2_hold_0100", disp, 16'h0100);
    cyc(1);
    check("s2_borrow_0059", disp, 16'h0059);
    i_clear = 1'b1; cyc(); i_clear = 1'b0;
    pulse_min(10);
    check("s2_set_1000", disp, 16'h1000);
    pulse_run();
    cyc(10);
    check("s2_borrow_0959", disp, 16'h0959);
    i_clear = 1'b1; cyc(); i_clear = 1'b0;

    // Set wraps
    do_reset();
    pulse_sec(59);
    check("s3_sec_59", disp, 16'h0059);
    pulse_sec(1);
    check("s3_sec_wrap", disp, 16'h0000);
    pulse_min(61);
    check("s3_min_wrap", disp, 16'h0100);

    // Pause / resume with held prescaler
    do_reset();
    pulse_sec(5);
    pulse_run();
    cyc(4);
    pulse_run();
    check("s4_paused", {15'd0, o_running}, 16'd0);
    cyc(50);
    pulse_sec(1);
    cyc(49);
    check("s4_frozen", disp, 16'h0005);
    pulse_run();
    check("s4_resumed", {15'd0, o_running}, 16'd1);
    cyc(5);
    check("s4_resume_hold", disp, 16'h0005);
    cyc(1);
    check("s4_resume_tick", disp, 16'h0004);

    // Clear beats finish; async reset mid-run
    do_reset();
    pulse_sec(1);
    pulse_run();
    cyc(10);
    check("s5_in_finish", {15'd0, o_finish_req}, 16'd1);
    i_clear = 1'b1; i_finish = 1'b1; cyc(); i_clear = 1'b0; i_finish = 1'b0;
    check("s5_clr_freq", {15'd0, o_finish_req}, 16'd0);
    check("s5_clr_disp", disp, 16'h0000);
    check("s5_clr_no_done", {15'd0, o_done}, 16'd0);
    cyc();
    check("s5_clr_no_done_late", {15'd0, o_done}, 16'd0);
    pulse_sec(2);
    pulse_run();
    cyc(3);
    #2;
    reset = 1'b0;
    #1;
    check("s5_rst_disp", disp, 16'h0000);
    check("s5_rst_flags", {12'd0, o_running, o_finish_req, o_done, o_timeout}, 16'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // FINISH wait: timeout with the macro, indefinite without
    do_reset();
    pulse_sec(2);
    pulse_run();
    cyc(20);
    check("s6_finish", {15'd0, o_finish_req}, 16'd1);
`ifdef CDT_FINISH_TIMEOUT_EN
    cyc(199);
    check("s6_no_timeout_yet", {14'd0, o_timeout, o_finish_req}, 16'd1);
    cyc(1);
    check("s6_timeout", {14'd0, o_timeout, o_finish_req}, 16'd2);
    check("s6_reload", disp, 16'h0002);
    check("s6_no_done", {15'd0, o_done}, 16'd0);
    cyc(1);
    check("s6_timeout_pulse", {15'd0, o_timeout}, 16'd0);
`else
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (o_finish_req !== 1'b1 || o_timeout !== 1'b0) bad++;
    end
    check("s6_wait_forever", bad[15:0], 16'd0);
    check("s6_disp_zero", disp, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
